// File: rtl/line_pattern_gen.sv
// Line-at-a-time test pattern generator: streams H_ACTIVE pixels per request
// through a ready/enable write port, with registered address and data.
module line_pattern_gen #(
    parameter int unsigned          H_ACTIVE  = 800,
    parameter int unsigned          ADDR_W    = 10,
    parameter int unsigned          DATA_W    = 24,
    parameter int unsigned          LINE_W    = 10,
    parameter int unsigned          TILE_LOG2 = 3,
    parameter logic [DATA_W-1:0]    COLOR_A   = 24'h888888,
    parameter logic [DATA_W-1:0]    COLOR_B   = 24'h444444
) (
    input  logic              clk_psram,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic              line_req,
    input  logic [LINE_W-1:0] line_idx,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              line_done,
    output logic              overrun
);

    localparam int unsigned       C        = DATA_W / 3;
    localparam int unsigned       BAR_W    = H_ACTIVE / 8;
    localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LAST_BAR = ADDR_W'(BAR_W - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    logic [2:0]          r_mode;
    logic [LINE_W-1:0]   r_y;
    logic [ADDR_W-1:0]   r_x;
    logic [ADDR_W-1:0]   r_frame_cnt;
    logic [2:0]          r_bar_idx;
    logic [ADDR_W-1:0]   r_bar_cnt;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic                r_busy;
    logic                r_line_done;
    logic                r_overrun;

    logic [ADDR_W-1:0]   w_frame_next;
    logic [2:0]          w_bar_idx_nxt;
    logic [ADDR_W-1:0]   w_bar_cnt_nxt;
    logic [2:0]          w_px_mode;
    logic [ADDR_W-1:0]   w_px_x;
    logic [LINE_W-1:0]   w_px_y;
    logic [ADDR_W-1:0]   w_px_frame;
    logic [2:0]          w_px_bar;
    logic [ADDR_W-1:0]   w_xs;
    logic [C+ADDR_W-1:0] w_x_ext;
    logic [2:0]          w_rgb;
    logic [DATA_W-1:0]   w_pix;
    logic                w_accept;

    assign w_accept     = r_wr_en & wr_ready;
    assign w_frame_next = r_frame_cnt + ((line_idx == '0) ? ADDR_W'(1) : ADDR_W'(0));

    // Bar position tracked incrementally so no divide by BAR_W is needed.
    always_comb begin
        w_bar_idx_nxt = r_bar_idx;
        w_bar_cnt_nxt = r_bar_cnt + ADDR_W'(1);
        if (r_bar_cnt == LAST_BAR && r_bar_idx != 3'd7) begin
            w_bar_idx_nxt = r_bar_idx + 3'd1;
            w_bar_cnt_nxt = '0;
        end
    end

    // Pixel is computed for the address about to be presented: x=0 at accept, x+1 on each write.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_px_mode  = mode;
            w_px_x     = '0;
            w_px_y     = line_idx;
            w_px_frame = w_frame_next;
            w_px_bar   = '0;
        end else begin
            w_px_mode  = r_mode;
            w_px_x     = r_x + ADDR_W'(1);
            w_px_y     = r_y;
            w_px_frame = r_frame_cnt;
            w_px_bar   = w_bar_idx_nxt;
        end
    end

    always_comb begin
        w_xs    = w_px_x + w_px_frame;
        w_x_ext = (C + ADDR_W)'(w_px_x);
        unique case (w_px_bar)
            3'd0:    w_rgb = 3'b111;
            3'd1:    w_rgb = 3'b110;
            3'd2:    w_rgb = 3'b011;
            3'd3:    w_rgb = 3'b010;
            3'd4:    w_rgb = 3'b101;
            3'd5:    w_rgb = 3'b100;
            3'd6:    w_rgb = 3'b001;
            default: w_rgb = 3'b000;
        endcase
        unique case (w_px_mode)
            3'd0:    w_pix = COLOR_A;
            3'd1:    w_pix = (w_px_x[TILE_LOG2] ^ w_px_y[TILE_LOG2]) ? COLOR_A : COLOR_B;
            3'd2:    w_pix = DATA_W'({{C{w_rgb[2]}}, {C{w_rgb[1]}}, {C{w_rgb[0]}}});
            3'd3:    w_pix = DATA_W'({3{w_x_ext[C-1:0]}});
            3'd4:    w_pix = (w_xs[TILE_LOG2] ^ w_px_y[TILE_LOG2]) ? COLOR_A : COLOR_B;
            default: w_pix = '0;
        endcase
    end

    always_ff @(posedge clk_psram) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_y         <= '0;
            r_x         <= '0;
            r_frame_cnt <= '0;
            r_bar_idx   <= '0;
            r_bar_cnt   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_line_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            if (line_req && r_busy) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (line_req) begin
                        r_mode      <= mode;
                        r_y         <= line_idx;
                        r_frame_cnt <= w_frame_next;
                        r_x         <= '0;
                        r_bar_idx   <= '0;
                        r_bar_cnt   <= '0;
                        r_wr_data   <= w_pix;
                        r_wr_en     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_x == LAST_X) begin
                            r_wr_en     <= 1'b0;
                            r_busy      <= 1'b0;
                            r_line_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_x       <= r_x + ADDR_W'(1);
                            r_bar_idx <= w_bar_idx_nxt;
                            r_bar_cnt <= w_bar_cnt_nxt;
                            r_wr_data <= w_pix;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_addr   = r_x;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign line_done = r_line_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_line_pattern_gen.sv
// Directed bench for line_pattern_gen: table of per-pixel expectations over
// captured lines, plus hand sequences for stall, overrun and mid-line reset.
module tb_line_pattern_gen;

    logic        clk_psram = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        line_req;
    logic [9:0]  line_idx;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        line_done;
    logic        overrun;

    line_pattern_gen dut (
        .clk_psram (clk_psram),
        .rst       (rst),
        .mode      (mode),
        .line_req  (line_req),
        .line_idx  (line_idx),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .line_done (line_done),
        .overrun   (overrun)
    );

    always #5 clk_psram = ~clk_psram;

    typedef struct {
        int          ln;
        bit          rst_first;
        logic [2:0]  m;
        logic [9:0]  idx;
        int          x;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs[64];
    int          nv    = 0;
    int          nvec  = 0;
    int          nfail = 0;
    logic [23:0] cap[800];

    task automatic add(input int ln, input bit rf, input logic [2:0] m,
                       input logic [9:0] idx, input int x, input logic [23:0] exp);
        vecs[nv] = '{ln, rf, m, idx, x, exp};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_psram);
        rst = 1'b0;
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge where line_done is seen.
    task automatic run_line(input logic [2:0] m, input logic [9:0] idx,
                            input int stall_at, input int ovr_at, input int rst_at);
        int          acc;
        int          cyc;
        int          stall_n;
        bit          ovr_done;
        bit          done;
        bit          seq_ok;
        bit          quiet;
        logic [23:0] hold_d;
        mode = m; line_idx = idx; line_req = 1'b1; wr_ready = 1'b1;
        @(negedge clk_psram);
        line_req = 1'b0; mode = ~m; line_idx = ~idx;
        chk("start_en", {31'd0, wr_en}, 32'd1);
        chk("start_addr", {22'd0, wr_addr}, 32'd0);
        acc = 0; cyc = 0; stall_n = 0; ovr_done = 1'b0; done = 1'b0; seq_ok = 1'b1;
        hold_d = '0;
        while (!done && cyc < 3000) begin
            line_req = 1'b0;
            wr_ready = 1'b1;
            if (line_done) begin
                done = 1'b1;
            end else begin
                if (rst_at >= 0 && int'(wr_addr) == rst_at) begin
                    do_reset();
                    chk("rst_en", {31'd0, wr_en}, 32'd0);
                    chk("rst_busy", {31'd0, busy}, 32'd0);
                    chk("rst_addr", {22'd0, wr_addr}, 32'd0);
                    chk("rst_ovr", {31'd0, overrun}, 32'd0);
                    quiet = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (line_done || busy || wr_en) quiet = 1'b0;
                        @(negedge clk_psram);
                    end
                    chk("rst_no_done", {31'd0, quiet}, 32'd1);
                    return;
                end
                if (stall_at >= 0 && int'(wr_addr) == stall_at && stall_n < 5) begin
                    wr_ready = 1'b0;
                    if (stall_n == 0) hold_d = wr_data;
                    else begin
                        chk("stall_addr", {22'd0, wr_addr}, stall_at);
                        chk("stall_data", {8'd0, wr_data}, {8'd0, hold_d});
                    end
                    stall_n++;
                end
                if (ovr_at >= 0 && int'(wr_addr) == ovr_at && !ovr_done) begin
                    line_req = 1'b1;
                    ovr_done = 1'b1;
                end
                if (wr_en && wr_ready) begin
                    if (int'(wr_addr) != acc) seq_ok = 1'b0;
                    cap[wr_addr] = wr_data;
                    acc++;
                end else if (!wr_en) begin
                    seq_ok = 1'b0;
                end
                @(negedge clk_psram);
                cyc++;
            end
        end
        line_req = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        if (!done) begin
            $display("FAIL timeout: no line_done within cycle budget");
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
            $fatal(1, "line did not complete");
        end
        chk("accepts", acc, 800);
        chk("sequence", {31'd0, seq_ok}, 32'd1);
        chk("done_en", {31'd0, wr_en}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int prev_ln;
        rst = 1'b1; line_req = 1'b0; wr_ready = 1'b1; mode = '0; line_idx = '0;
        repeat (3) @(negedge clk_psram);
        chk("reset_en", {31'd0, wr_en}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, line_done}, 32'd0);
        chk("reset_ovr", {31'd0, overrun}, 32'd0);
        chk("reset_addr", {22'd0, wr_addr}, 32'd0);
        chk("reset_data", {8'd0, wr_data}, 32'd0);
        rst = 1'b0;

        add(0, 0, 3'd0, 10'd5, 0,   24'h888888);
        add(0, 0, 3'd0, 10'd5, 799, 24'h888888);
        add(1, 0, 3'd1, 10'd8, 0,   24'h888888);
        add(1, 0, 3'd1, 10'd8, 7,   24'h888888);
        add(1, 0, 3'd1, 10'd8, 8,   24'h444444);
        add(1, 0, 3'd1, 10'd8, 15,  24'h444444);
        add(1, 0, 3'd1, 10'd8, 16,  24'h888888);
        add(1, 0, 3'd1, 10'd8, 799, 24'h444444);
        add(2, 0, 3'd1, 10'd0, 0,   24'h444444);
        add(2, 0, 3'd1, 10'd0, 8,   24'h888888);
        add(3, 0, 3'd2, 10'd0, 0,   24'hFFFFFF);
        add(3, 0, 3'd2, 10'd0, 99,  24'hFFFFFF);
        add(3, 0, 3'd2, 10'd0, 100, 24'hFFFF00);
        add(3, 0, 3'd2, 10'd0, 200, 24'h00FFFF);
        add(3, 0, 3'd2, 10'd0, 300, 24'h00FF00);
        add(3, 0, 3'd2, 10'd0, 400, 24'hFF00FF);
        add(3, 0, 3'd2, 10'd0, 500, 24'hFF0000);
        add(3, 0, 3'd2, 10'd0, 600, 24'h0000FF);
        add(3, 0, 3'd2, 10'd0, 699, 24'h0000FF);
        add(3, 0, 3'd2, 10'd0, 700, 24'h000000);
        add(3, 0, 3'd2, 10'd0, 799, 24'h000000);
        add(4, 0, 3'd3, 10'd3, 0,   24'h000000);
        add(4, 0, 3'd3, 10'd3, 5,   24'h050505);
        add(4, 0, 3'd3, 10'd3, 255, 24'hFFFFFF);
        add(4, 0, 3'd3, 10'd3, 256, 24'h000000);
        add(4, 0, 3'd3, 10'd3, 799, 24'h1F1F1F);
        add(5, 0, 3'd5, 10'd1, 10,  24'h000000);
        add(6, 0, 3'd7, 10'd2, 3,   24'h000000);
        // frame_cnt cleared, then two line-0 frames: offsets 1 then 2
        add(7, 1, 3'd4, 10'd0, 6,   24'h444444);
        add(7, 1, 3'd4, 10'd0, 7,   24'h888888);
        add(8, 0, 3'd4, 10'd0, 0,   24'h444444);
        add(8, 0, 3'd4, 10'd0, 5,   24'h444444);
        add(8, 0, 3'd4, 10'd0, 6,   24'h888888);
        add(8, 0, 3'd4, 10'd0, 13,  24'h888888);
        add(8, 0, 3'd4, 10'd0, 14,  24'h444444);

        prev_ln = -1;
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].ln != prev_ln) begin
                if (vecs[i].rst_first) do_reset();
                run_line(vecs[i].m, vecs[i].idx, -1, -1, -1);
                prev_ln = vecs[i].ln;
            end
            chk($sformatf("vec%0d_m%0d_x%0d", i, vecs[i].m, vecs[i].x),
                {8'd0, cap[vecs[i].x]}, {8'd0, vecs[i].exp});
        end

        run_line(3'd1, 10'd8, 37, -1, -1);
        chk("stall_x36", {8'd0, cap[36]}, 32'h00888888);
        chk("stall_x37", {8'd0, cap[37]}, 32'h00888888);
        chk("stall_x38", {8'd0, cap[38]}, 32'h00888888);

        chk("ovr_before", {31'd0, overrun}, 32'd0);
        run_line(3'd0, 10'd1, -1, 300, -1);
        chk("ovr_after", {31'd0, overrun}, 32'd1);
        @(negedge clk_psram);
        @(negedge clk_psram);
        chk("ovr_no_restart", {30'd0, busy, wr_en}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        run_line(3'd2, 10'd0, -1, -1, 400);
        run_line(3'd3, 10'd3, -1, -1, -1);
        chk("after_rst_x0", {8'd0, cap[0]}, 32'h00000000);
        chk("after_rst_x5", {8'd0, cap[5]}, 32'h00050505);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
